// File: rtl/shift_out_tx_if.sv
// Handshake and serial-output bundle for shift_out_tx; master drives the
// request side, slave is the transmitter.
interface shift_out_tx_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] data_in;
   logic             serial_out;
   logic             serial_out_n;
   logic             busy;
   logic             done;

   modport master (
      output start,
      output data_in,
      input  serial_out,
      input  serial_out_n,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  data_in,
      output serial_out,
      output serial_out_n,
      output busy,
      output done
   );
endinterface

// File: rtl/shift_out_tx.sv
// Parallel-to-serial transmitter: captures a WIDTH-bit word on start and
// shifts it out MSB first, holding each bit for DIV clock cycles.
module shift_out_tx #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic          clock,
   input  logic          reset,
   shift_out_tx_if.slave bus
);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           r_state,  w_state_nxt;
   logic [WIDTH-1:0] r_shreg,  w_shreg_nxt;
   logic [BIT_W-1:0] r_bitcnt, w_bitcnt_nxt;
   logic [DIV_W-1:0] r_divcnt, w_divcnt_nxt;
   logic             r_busy,   w_busy_nxt;
   logic             r_done,   w_done_nxt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_shreg  <= '0;
         r_bitcnt <= '0;
         r_divcnt <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_shreg  <= w_shreg_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_divcnt <= w_divcnt_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // The shift register MSB is the serial line itself, so it is cleared
   // whenever the line must idle low.
   always_comb begin
      w_state_nxt  = r_state;
      w_shreg_nxt  = r_shreg;
      w_bitcnt_nxt = r_bitcnt;
      w_divcnt_nxt = r_divcnt;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy_nxt = 1'b0;
            if (bus.start) begin
               w_shreg_nxt  = bus.data_in;
               w_bitcnt_nxt = '0;
               w_divcnt_nxt = '0;
               w_busy_nxt   = 1'b1;
               w_state_nxt  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_divcnt == DIV_LAST) begin
               w_divcnt_nxt = '0;
               if (r_bitcnt == BIT_LAST) begin
                  w_shreg_nxt = '0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end else begin
                  w_shreg_nxt  = {r_shreg[WIDTH-2:0], 1'b0};
                  w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
               end
            end else begin
               w_divcnt_nxt = r_divcnt + DIV_W'(1);
            end
         end
         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_shreg_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.serial_out   = r_shreg[WIDTH-1];
   assign bus.serial_out_n = ~r_shreg[WIDTH-1];
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
endmodule

// File: tb/tb_shift_out_tx.sv
// Directed bench for shift_out_tx: an 8-bit/DIV=4 instance and a
// 2-bit/DIV=1 instance sharing one clock and reset.
module tb_shift_out_tx;
   logic clock;
   logic reset;
   logic armed;
   int   n_tests;
   int   n_fail;

   shift_out_tx_if #(.WIDTH(8)) busA ();
   shift_out_tx_if #(.WIDTH(2)) busB ();

   shift_out_tx #(.WIDTH(8), .DIV(4)) u_dutA (
      .clock (clock),
      .reset (reset),
      .bus   (busA.slave)
   );

   shift_out_tx #(.WIDTH(2), .DIV(1)) u_dutB (
      .clock (clock),
      .reset (reset),
      .bus   (busB.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // Every cycle after the first reset edge: complement and busy/done exclusion.
   always @(negedge clock) begin
      if (armed) begin
         check("cmplA", busA.serial_out_n ^ busA.serial_out, 1);
         check("cmplB", busB.serial_out_n ^ busB.serial_out, 1);
         check("excA", busA.busy & busA.done, 0);
         check("excB", busB.busy & busB.done, 0);
      end
   end

   task automatic frame8(input logic [7:0] d, input bit hold, input bit scramble);
      busA.data_in = d;
      busA.start   = 1'b1;
      tick();
      if (!hold) busA.start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         for (int c = 0; c < 4; c++) begin
            check("bit", busA.serial_out, d[7-i]);
            check("busy", busA.busy, 1);
            check("nodone", busA.done, 0);
            if (scramble) busA.data_in = 8'($urandom);
            tick();
         end
      end
      check("done", busA.done, 1);
      check("done_busy", busA.busy, 0);
      check("done_so", busA.serial_out, 0);
      tick();
      if (hold) begin
         check("gap_busy", busA.busy, 0);
         check("gap_so", busA.serial_out, 0);
         check("gap_done", busA.done, 0);
         tick();
         check("restart_busy", busA.busy, 1);
         check("restart_so", busA.serial_out, 1);
         busA.start = 1'b0;
      end else begin
         check("post_done", busA.done, 0);
         check("post_busy", busA.busy, 0);
      end
   endtask

   task automatic frame2(input logic [1:0] d);
      busB.data_in = d;
      busB.start   = 1'b1;
      tick();
      busB.start = 1'b0;
      check("b2_bit1", busB.serial_out, d[1]);
      check("b2_busy1", busB.busy, 1);
      tick();
      check("b2_bit0", busB.serial_out, d[0]);
      check("b2_busy0", busB.busy, 1);
      tick();
      check("b2_done", busB.done, 1);
      check("b2_so", busB.serial_out, 0);
      tick();
      check("b2_post", busB.done, 0);
   endtask

   initial begin
      logic saw_done;
      n_tests = 0;
      n_fail  = 0;
      armed   = 1'b0;
      reset   = 1'b1;
      busA.start = 1'b0; busA.data_in = '0;
      busB.start = 1'b0; busB.data_in = '0;
      tick();
      armed = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_so", busA.serial_out, 0);
      check("rst_son", busA.serial_out_n, 1);
      check("rst_busy", busA.busy, 0);
      check("rst_done", busA.done, 0);
      tick();
      check("idle_so", busA.serial_out, 0);
      check("idle_busy", busA.busy, 0);
      check("idle_done", busA.done, 0);

      frame8(8'hA5, 1'b0, 1'b0);
      frame8(8'hFF, 1'b1, 1'b0);

      // Abort the restarted frame left over from the held-start test.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort1_busy", busA.busy, 0);

      busA.data_in = 8'h3C;
      busA.start   = 1'b1;
      tick();
      busA.start = 1'b0;
      repeat (9) tick();
      check("mid_busy", busA.busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busA.busy, 0);
      check("abort_so", busA.serial_out, 0);
      check("abort_done", busA.done, 0);
      saw_done = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (busA.done) saw_done = 1'b1;
         tick();
      end
      check("abort_nodone", saw_done, 0);

      frame8(8'h81, 1'b0, 1'b0);
      frame8(8'h5A, 1'b0, 1'b1);

      frame2(2'b10);
      frame2(2'b01);

      armed = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
